// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches single-cycle event strobes into pulses with a guaranteed ON width and OFF gap
//   clk        in   clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   event_i    in   request strobe, each high cycle is one event
//   ovf_clr_i  in   clears the sticky overflow flag
//   pulse_o    out  stretched output pulse (registered)
//   busy_o     out  high in ON or GAP (registered)
//   pending_o  out  queued events not yet started
//   overflow_o out  sticky, an event was dropped with the queue full
module pulse_stretcher #(
  parameter int ON_CYCLES  = 5,
  parameter int OFF_CYCLES = 5,
  parameter int CNT_W      = 3,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_i,
  input  logic              ovf_clr_i,
  output logic              pulse_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);
  typedef enum logic [1:0] {IDLE, ON, GAP} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic overflow_q, overflow_d, pulse_q, pulse_d, busy_q, busy_d;
  logic cnt_zero, gap_end, has_pend, deq, start, enq, full, drop;
  assign cnt_zero = cnt_q == '0;
  assign gap_end  = state_q == GAP && cnt_zero;
  assign has_pend = pending_q != '0;
  assign deq      = gap_end && has_pend;
  // An event on the last GAP cycle with nothing queued starts the next pulse
  // directly instead of being queued into IDLE, where it would never be served.
  assign start    = event_i && (state_q == IDLE || (gap_end && !has_pend));
  assign enq      = event_i && !start;
  assign full     = pending_q == '1;
  assign drop     = enq && full && !deq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = start ? ON : IDLE;
        cnt_d   = start ? CNT_W'(ON_CYCLES - 1) : '0;
      end
      ON: begin
        state_d = cnt_zero ? GAP : ON;
        cnt_d   = cnt_zero ? CNT_W'(OFF_CYCLES - 1) : cnt_q - 1'b1;
      end
      GAP: begin
        state_d = !cnt_zero ? GAP : (deq || start) ? ON : IDLE;
        cnt_d   = !cnt_zero ? cnt_q - 1'b1 : (deq || start) ? CNT_W'(ON_CYCLES - 1) : '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_comb begin
    pulse_d    = state_d == ON;
    busy_d     = state_d != IDLE;
    pending_d  = (enq && !deq && !full) ? pending_q + PEND_W'(1) :
                 (deq && !enq)          ? pending_q - PEND_W'(1) : pending_q;
    overflow_d = drop ? 1'b1 : ovf_clr_i ? 1'b0 : overflow_q;
  end
  assign pulse_o    = pulse_q;
  assign busy_o     = busy_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: scoreboard bench for pulse_stretcher against a period-countdown model
module tb_pulse_stretcher;
  localparam int ON = 5, OFF = 5, PER = ON + OFF, QMAX = 7;
  typedef struct {
    logic       p;
    logic       b;
    logic [2:0] pn;
    logic       o;
  } exp_t;
  logic clk, rst_n, event_i, ovf_clr_i, pulse_o, busy_o, overflow_o;
  logic [2:0] pending_o;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int m_t = 0, m_pend = 0, rises = 0;
  logic m_ovf = 1'b0, prev_pulse = 1'b0;
  pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(3), .PEND_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .ovf_clr_i(ovf_clr_i),
    .pulse_o(pulse_o), .busy_o(busy_o), .pending_o(pending_o), .overflow_o(overflow_o)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  task automatic step(input logic e, input logic c);
    exp_t x;
    logic set;
    @(negedge clk);
    event_i = e;
    ovf_clr_i = c;
    set = 1'b0;
    if (m_t == 0) begin
      if (e) m_t = PER;
    end else if (m_t == 1) begin
      if (m_pend > 0) begin
        m_t = PER;
        if (!e) m_pend--;
      end else m_t = e ? PER : 0;
    end else begin
      m_t--;
      if (e) begin
        if (m_pend < QMAX) m_pend++;
        else set = 1'b1;
      end
    end
    m_ovf = set ? 1'b1 : c ? 1'b0 : m_ovf;
    x.p = m_t > OFF;
    x.b = m_t > 0;
    x.pn = 3'(m_pend);
    x.o = m_ovf;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("pulse", 32'(pulse_o), 32'(x.p));
    check("busy", 32'(busy_o), 32'(x.b));
    check("pending", 32'(pending_o), 32'(x.pn));
    check("overflow", 32'(overflow_o), 32'(x.o));
    if (pulse_o && !prev_pulse) rises++;
    prev_pulse = pulse_o;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_pulse"}, 32'(pulse_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_pending"}, 32'(pending_o), 0);
    check({tag, "_overflow"}, 32'(overflow_o), 0);
  endtask
  task automatic arst();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    m_t = 0;
    m_pend = 0;
    m_ovf = 1'b0;
    prev_pulse = 1'b0;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      event_i = ~event_i;
      @(posedge clk);
      #1 check_zero("in_rst");
    end
    @(negedge clk);
    event_i = 1'b0;
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    event_i = 1'b0;
    ovf_clr_i = 1'b0;
    #3 check_zero("por");
    repeat (3) begin
      @(negedge clk);
      event_i = ~event_i;
      @(posedge clk);
      #1 check_zero("por_hold");
    end
    @(negedge clk);
    event_i = 1'b0;
    rst_n = 1'b1;
    repeat (3) step(0, 0);
    // single event
    step(1, 0);
    repeat (12) step(0, 0);
    // three events queue two
    repeat (3) step(1, 0);
    check("three_pend", 32'(pending_o), 2);
    repeat (32) step(0, 0);
    // saturation, eight pulses, then clear
    rises = 0;
    repeat (10) step(1, 0);
    check("sat_ovf", 32'(overflow_o), 1);
    repeat (75) step(0, 0);
    check("sat_rises", 32'(rises), 8);
    step(0, 1);
    check("ovf_clr", 32'(overflow_o), 0);
    // event on dequeue edge with full queue
    repeat (8) step(1, 0);
    repeat (2) step(0, 0);
    step(1, 0);
    check("deq_pend", 32'(pending_o), 7);
    check("deq_ovf", 32'(overflow_o), 0);
    // set beats clear
    step(1, 1);
    check("set_prio", 32'(overflow_o), 1);
    repeat (80) step(0, 0);
    step(0, 1);
    // reset mid-pulse with queued events
    repeat (5) step(1, 0);
    check("mid_pend", 32'(pending_o), 4);
    check("mid_pulse", 32'(pulse_o), 1);
    arst();
    rises = 0;
    repeat (30) step(0, 0);
    check("post_rst_rises", 32'(rises), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
